// File: rtl/imem_dmem_arbiter_pkg.sv
// Request/response types shared by the instruction port, the data port and the memory bus.
package imem_dmem_arbiter_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_spec;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_ready;
    } mem_out_type;

endpackage

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one shared memory port between an instruction and a data requester,
// one outstanding request per port, fixed (data wins) or round-robin priority.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned ARB_MODE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  ireq_in,
    output mem_out_type ireq_out,
    input  mem_in_type  dreq_in,
    output mem_out_type dreq_out,
    output mem_in_type  mem_in,
    input  mem_out_type mem_out
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e     state_q, state_d;
    mem_in_type out_q, out_d;
    mem_in_type pend_i_q, pend_i_d;
    mem_in_type pend_d_q, pend_d_d;
    logic       owner_q, owner_d;           // 1: data port owns the bus
    logic       last_grant_q, last_grant_d; // 1: data was granted last

    logic       busy, done, arb;
    logic       i_idle, d_idle, i_acc, d_acc;
    logic       cand_i, cand_d, grant_i, grant_d;
    mem_in_type req_i, req_d;

    assign busy = (state_q == StBusy);
    assign done = busy && mem_out.mem_ready;
    assign arb  = !busy || done;

    // The owner counts as idle in its completion cycle, so it may re-issue immediately.
    assign i_idle = !pend_i_q.mem_valid && !(busy && !owner_q && !done);
    assign d_idle = !pend_d_q.mem_valid && !(busy && owner_q && !done);
    assign i_acc  = ireq_in.mem_valid && i_idle;
    assign d_acc  = dreq_in.mem_valid && d_idle;

    assign cand_i = pend_i_q.mem_valid || i_acc;
    assign cand_d = pend_d_q.mem_valid || d_acc;
    assign req_i  = pend_i_q.mem_valid ? pend_i_q : ireq_in;
    assign req_d  = pend_d_q.mem_valid ? pend_d_q : dreq_in;

    assign grant_d = arb && cand_d && (!cand_i || (ARB_MODE == 0) || !last_grant_q);
    assign grant_i = arb && cand_i && !grant_d;

    always_comb begin
        state_d      = state_q;
        out_d        = out_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        pend_i_d     = pend_i_q;
        pend_d_d     = pend_d_q;

        if (i_acc) pend_i_d = ireq_in;
        if (d_acc) pend_d_d = dreq_in;

        if (done) state_d = StIdle;

        if (grant_d) begin
            out_d        = req_d;
            owner_d      = 1'b1;
            last_grant_d = 1'b1;
            state_d      = StBusy;
            pend_d_d     = '0;
        end else if (grant_i) begin
            out_d        = req_i;
            owner_d      = 1'b0;
            last_grant_d = 1'b0;
            state_d      = StBusy;
            pend_i_d     = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            out_q        <= '0;
            pend_i_q     <= '0;
            pend_d_q     <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            pend_i_q     <= pend_i_d;
            pend_d_q     <= pend_d_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Outputs are forced to zero while reset is held, even before the synchronous edge.
    always_comb begin
        mem_in   = '0;
        ireq_out = '0;
        dreq_out = '0;
        if (reset && busy) begin
            mem_in           = out_q;
            mem_in.mem_valid = 1'b1;
            if (mem_out.mem_ready) begin
                if (owner_q) dreq_out = mem_out;
                else         ireq_out = mem_out;
            end
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench: one arbiter per ARB_MODE, shared random request stimulus,
// per-instance memory responder, transaction-level model and output monitor.
module tb_imem_dmem_arbiter;
    import imem_dmem_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    mem_in_type  ireq_in, dreq_in;
    mem_out_type ireq_out [2];
    mem_out_type dreq_out [2];
    mem_in_type  mem_in   [2];
    mem_out_type mem_out  [2];

    bit mem_hold;
    bit rogue;
    int total;
    int bad;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    function automatic mem_in_type mk(input bit v, input logic [31:0] a);
        mem_in_type r;
        r.mem_valid = v;
        r.mem_fence = 1'($urandom_range(0, 1));
        r.mem_spec  = 1'($urandom_range(0, 1));
        r.mem_instr = 1'($urandom_range(0, 1));
        r.mem_addr  = a;
        r.mem_wdata = $urandom;
        r.mem_wstrb = 4'($urandom_range(0, 15));
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_h
        imem_dmem_arbiter #(.ARB_MODE(g)) u_dut (
            .clock    (clock),
            .reset    (reset),
            .ireq_in  (ireq_in),
            .ireq_out (ireq_out[g]),
            .dreq_in  (dreq_in),
            .dreq_out (dreq_out[g]),
            .mem_in   (mem_in[g]),
            .mem_out  (mem_out[g])
        );

        mem_in_type  bus_q [$];
        logic [31:0] rsp_q [2][$];

        // Memory responder: 0..3 wait cycles per transaction.
        initial begin
            bit started;
            bit drove_ready;
            int wait_n;
            started     = 0;
            drove_ready = 0;
            wait_n      = 0;
            mem_out[g]  = '0;
            forever begin
                @(posedge clock);
                #1;
                if (rogue) begin
                    mem_out[g]  = '{mem_rdata: 32'hBAD0_BAD0, mem_ready: 1'b1};
                    started     = 0;
                    drove_ready = 0;
                end else begin
                    mem_out[g] = '0;
                    if (drove_ready || !mem_in[g].mem_valid) started = 0;
                    drove_ready = 0;
                    if (mem_in[g].mem_valid && !started) begin
                        started = 1;
                        wait_n  = $urandom_range(0, 3);
                    end
                    if (started && !mem_hold) begin
                        if (wait_n == 0) begin
                            mem_out[g]  = '{mem_rdata: mem_data(mem_in[g].mem_addr), mem_ready: 1'b1};
                            drove_ready = 1;
                        end else begin
                            wait_n--;
                        end
                    end
                end
            end
        end

        // Transaction-level reference: per-port outstanding flag, one bus owner.
        initial begin
            bit         has [2];
            bit         waiting [2];
            mem_in_type req [2];
            mem_in_type inp [2];
            bit         mbusy;
            int         owner, last, w;
            mbusy = 0; owner = 0; last = 0;
            has = '{0, 0}; waiting = '{0, 0};
            forever begin
                @(posedge clock);
                inp[0] = ireq_in;
                inp[1] = dreq_in;
                if (!reset) begin
                    has = '{0, 0}; waiting = '{0, 0};
                    mbusy = 0; owner = 0; last = 0;
                    bus_q.delete();
                    rsp_q[0].delete();
                    rsp_q[1].delete();
                end else begin
                    if (mbusy && mem_out[g].mem_ready) begin
                        has[owner] = 0;
                        mbusy      = 0;
                    end
                    for (int p = 0; p < 2; p++) begin
                        if (inp[p].mem_valid && !has[p]) begin
                            has[p]     = 1;
                            waiting[p] = 1;
                            req[p]     = inp[p];
                            rsp_q[p].push_back(mem_data(inp[p].mem_addr));
                        end
                    end
                    if (!mbusy && (waiting[0] || waiting[1])) begin
                        if (waiting[0] && waiting[1]) w = (g == 0) ? 1 : 1 - last;
                        else w = waiting[1] ? 1 : 0;
                        waiting[w] = 0;
                        mbusy      = 1;
                        owner      = w;
                        last       = w;
                        bus_q.push_back(req[w]);
                    end
                end
            end
        end

        // Monitor: bus transactions in order and stable, responses only to the owner.
        initial begin
            bit          tx_open;
            mem_in_type  snap;
            mem_in_type  exp_req;
            mem_out_type outs [2];
            tx_open = 0;
            snap    = '0;
            forever begin
                @(negedge clock);
                outs[0] = ireq_out[g];
                outs[1] = dreq_out[g];
                if (!reset) begin
                    check($sformatf("m%0d_rst_mem_in", g), 128'(mem_in[g]), 128'(0));
                    check($sformatf("m%0d_rst_ireq_out", g), 128'(outs[0]), 128'(0));
                    check($sformatf("m%0d_rst_dreq_out", g), 128'(outs[1]), 128'(0));
                    tx_open = 0;
                end else begin
                    if (mem_in[g].mem_valid) begin
                        if (!tx_open) begin
                            check($sformatf("m%0d_bus_expected", g), 128'(bus_q.size() != 0), 128'(1));
                            if (bus_q.size() != 0) begin
                                exp_req = bus_q.pop_front();
                                check($sformatf("m%0d_bus_req", g), 128'(mem_in[g]), 128'(exp_req));
                            end
                            snap = mem_in[g];
                        end else begin
                            check($sformatf("m%0d_bus_stable", g), 128'(mem_in[g]), 128'(snap));
                        end
                        tx_open = !mem_out[g].mem_ready;
                    end else begin
                        if (tx_open) check($sformatf("m%0d_valid_held", g), 128'(0), 128'(1));
                        tx_open = 0;
                    end
                    for (int p = 0; p < 2; p++) begin
                        if (outs[p].mem_ready) begin
                            check($sformatf("m%0d_p%0d_rsp_expected", g, p),
                                  128'(rsp_q[p].size() != 0), 128'(1));
                            if (rsp_q[p].size() != 0)
                                check($sformatf("m%0d_p%0d_rdata", g, p),
                                      128'(outs[p].mem_rdata), 128'(rsp_q[p].pop_front()));
                            check($sformatf("m%0d_p%0d_other_quiet", g, p),
                                  128'(outs[1-p]), 128'(0));
                        end else begin
                            check($sformatf("m%0d_p%0d_rdata_zero", g, p),
                                  128'(outs[p].mem_rdata), 128'(0));
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle(input int n);
        ireq_in = '0;
        dreq_in = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        mem_hold = 0;
        rogue    = 0;
        reset    = 1'b0;
        ireq_in  = mk(1, 32'h0000_0010);
        dreq_in  = mk(1, 32'h0000_0020);
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        ireq_in = '0;
        dreq_in = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            for (int g = 0; g < 2; g++)
                check($sformatf("m%0d_no_grant_after_reset", g), 128'(mem_in[g].mem_valid), 128'(0));
        end

        // Single instruction request.
        ireq_in = mk(1, 32'h0000_1000);
        step();
        idle(8);

        // Simultaneous instruction and data requests.
        ireq_in = mk(1, 32'h0000_0100);
        dreq_in = mk(1, 32'h0000_0200);
        step();
        idle(8);

        // Data held valid while instruction waits.
        ireq_in = mk(1, 32'h0000_0A00);
        for (int i = 0; i < 12; i++) begin
            dreq_in = mk(1, 32'h0000_2000 + 32'(i * 4));
            step();
            ireq_in = '0;
        end
        idle(10);

        // Reset during a busy transaction, then a stray ready while idle.
        mem_hold = 1;
        ireq_in  = mk(1, 32'h0000_0400);
        step();
        idle(3);
        reset = 1'b0;
        step();
        reset    = 1'b1;
        mem_hold = 0;
        idle(2);
        rogue = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            for (int g = 0; g < 2; g++) begin
                check($sformatf("m%0d_stray_ireq_ready", g), 128'(ireq_out[g].mem_ready), 128'(0));
                check($sformatf("m%0d_stray_dreq_ready", g), 128'(dreq_out[g].mem_ready), 128'(0));
            end
        end
        rogue = 0;
        idle(1);
        ireq_in = mk(1, 32'h0000_0500);
        step();
        idle(8);

        // Second data valid while the first is in flight.
        dreq_in = mk(1, 32'h0000_0200);
        step();
        dreq_in = '0;
        step();
        dreq_in = mk(1, 32'h0000_0300);
        step();
        idle(8);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            ireq_in = mk($urandom_range(0, 9) < 4, $urandom);
            dreq_in = mk($urandom_range(0, 9) < 4, $urandom);
            step();
        end
        idle(30);

        check("m0_drain_bus", 128'(g_h[0].bus_q.size()), 128'(0));
        check("m0_drain_irsp", 128'(g_h[0].rsp_q[0].size()), 128'(0));
        check("m0_drain_drsp", 128'(g_h[0].rsp_q[1].size()), 128'(0));
        check("m1_drain_bus", 128'(g_h[1].bus_q.size()), 128'(0));
        check("m1_drain_irsp", 128'(g_h[1].rsp_q[0].size()), 128'(0));
        check("m1_drain_drsp", 128'(g_h[1].rsp_q[1].size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
